// File: rtl/puf_challenge_sequencer_if.sv
// puf_challenge_sequencer_if
//
// Groups the control, PUF-facing and result signals of the arbiter-PUF
// challenge sequencer into one bundle. Clock and reset stay outside.
//
//   start, abort     run control into the sequencer
//   seed             initial challenge (zero is remapped to 1)
//   challenge        challenge word presented to the PUF mux chain
//   puf_pulse        race launch edge into the PUF delay line
//   puf_response     raw arbiter output, asynchronous to the clock
//   busy, done       run status and one-cycle completion pulse
//   key, key_valid   voted response word and its valid flag
//   unstable_cnt     count of challenges whose votes were not unanimous
//
// slave  : the sequencer side
// master : the tile control / PUF model side
interface puf_challenge_sequencer_if #(
  parameter int C_LENGTH = 8,
  parameter int N_RESP   = 16,
  parameter int CNT_W    = $clog2(N_RESP + 1)
);
  logic                start;
  logic                abort;
  logic [C_LENGTH-1:0] seed;
  logic [C_LENGTH-1:0] challenge;
  logic                puf_pulse;
  logic                puf_response;
  logic                busy;
  logic                done;
  logic [N_RESP-1:0]   key;
  logic                key_valid;
  logic [CNT_W-1:0]    unstable_cnt;

  modport slave (
    input  start, abort, seed, puf_response,
    output challenge, puf_pulse, busy, done, key, key_valid, unstable_cnt
  );

  modport master (
    output start, abort, seed, puf_response,
    input  challenge, puf_pulse, busy, done, key, key_valid, unstable_cnt
  );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
//
// Challenge-side driver for the arbiter PUF. Each run walks N_RESP
// challenges produced by an LFSR. For every challenge it fires VOTES race
// pulses (SETTLE cycles low, SETTLE cycles high), samples the synchronized
// arbiter response at the end of each high phase, majority-votes the
// samples into one key bit and counts non-unanimous challenges.
//
// Ports:
//   clk     single clock, all state on the rising edge
//   rst     asynchronous, active-high reset
//   bus_if  slave side of puf_challenge_sequencer_if (control, PUF, results)
module puf_challenge_sequencer #(
  parameter int                  C_LENGTH  = 8,
  parameter int                  N_RESP    = 16,
  parameter int                  VOTES     = 5,
  parameter int                  SETTLE    = 4,
  parameter logic [C_LENGTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                      clk,
  input  logic                      rst,
  puf_challenge_sequencer_if.slave  bus_if
);

  localparam int PH_W   = $clog2(SETTLE);
  localparam int VOTE_W = $clog2(VOTES + 1);
  localparam int IDX_W  = (N_RESP > 1) ? $clog2(N_RESP) : 1;
  localparam int CNT_W  = $clog2(N_RESP + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FIRE,
    COMMIT,
    DONE
  } state_t;

  state_t              state_q;
  logic [C_LENGTH-1:0] challenge_q;
  logic                pulse_q;
  logic                busy_q;
  logic                done_q;
  logic                key_valid_q;
  logic [N_RESP-1:0]   key_q;
  logic [CNT_W-1:0]    unstable_q;
  logic [PH_W-1:0]     phase_q;
  logic [VOTE_W-1:0]   votes_q;
  logic [VOTE_W-1:0]   ones_q;
  logic [IDX_W-1:0]    index_q;
  logic                sync1_q;
  logic                sync2_q;

  logic [C_LENGTH-1:0] lfsr_d;
  logic [C_LENGTH-1:0] seed_d;
  logic [VOTE_W-1:0]   votes_d;
  logic [VOTE_W-1:0]   ones_d;
  logic                vote_bit_d;
  logic                unanimous_d;
  logic                phase_last_d;

  // The arbiter output is asynchronous; only sync2_q is ever looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus_if.puf_response;
      sync2_q <= sync1_q;
    end
  end

  // A zero seed would lock the LFSR at zero forever, so it becomes 1.
  assign seed_d       = (bus_if.seed == '0) ? C_LENGTH'(1) : bus_if.seed;
  assign lfsr_d       = {challenge_q[C_LENGTH-2:0], ^(challenge_q & LFSR_TAPS)};
  assign votes_d      = votes_q + VOTE_W'(1);
  assign ones_d       = ones_q + VOTE_W'(sync2_q);
  assign vote_bit_d   = (ones_q > VOTE_W'(VOTES / 2));
  assign unanimous_d  = (ones_q == '0) || (ones_q == VOTE_W'(VOTES));
  assign phase_last_d = (phase_q == PH_W'(SETTLE - 1));

  // Sequencer FSM. All outputs are registered here so puf_pulse and
  // challenge never glitch; done is a default-low pulse raised only on
  // the COMMIT->DONE transition. DONE ignores abort so a finished run
  // always reports its completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      challenge_q <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      key_q       <= '0;
      unstable_q  <= '0;
      phase_q     <= '0;
      votes_q     <= '0;
      ones_q      <= '0;
      index_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus_if.abort && (state_q != IDLE) && (state_q != DONE)) begin
        state_q     <= IDLE;
        pulse_q     <= 1'b0;
        busy_q      <= 1'b0;
        key_valid_q <= 1'b0;
        phase_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus_if.start && !bus_if.abort) begin
              challenge_q <= seed_d;
              key_q       <= '0;
              unstable_q  <= '0;
              key_valid_q <= 1'b0;
              votes_q     <= '0;
              ones_q      <= '0;
              index_q     <= '0;
              phase_q     <= '0;
              busy_q      <= 1'b1;
              state_q     <= ARM;
            end
          end
          ARM: begin
            if (phase_last_d) begin
              phase_q <= '0;
              pulse_q <= 1'b1;
              state_q <= FIRE;
            end else begin
              phase_q <= phase_q + PH_W'(1);
            end
          end
          FIRE: begin
            if (phase_last_d) begin
              phase_q <= '0;
              pulse_q <= 1'b0;
              ones_q  <= ones_d;
              votes_q <= votes_d;
              state_q <= (votes_d == VOTE_W'(VOTES)) ? COMMIT : ARM;
            end else begin
              phase_q <= phase_q + PH_W'(1);
            end
          end
          COMMIT: begin
            key_q[index_q] <= vote_bit_d;
            if (!unanimous_d) begin
              unstable_q <= unstable_q + CNT_W'(1);
            end
            challenge_q <= lfsr_d;
            ones_q      <= '0;
            votes_q     <= '0;
            if (index_q == IDX_W'(N_RESP - 1)) begin
              done_q      <= 1'b1;
              key_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              index_q <= index_q + IDX_W'(1);
              state_q <= ARM;
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus_if.challenge    = challenge_q;
  assign bus_if.puf_pulse    = pulse_q;
  assign bus_if.busy         = busy_q;
  assign bus_if.done         = done_q;
  assign bus_if.key          = key_q;
  assign bus_if.key_valid    = key_valid_q;
  assign bus_if.unstable_cnt = unstable_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb_puf_challenge_sequencer
//
// Scoreboard bench for puf_challenge_sequencer. Stimulus pushes the
// expected challenge for every race pulse and the expected result of every
// run into queues; a monitor pops and compares as the DUT presents pulses
// and done. The monitor also plays the PUF, driving puf_response from a
// selectable response model.
module tb_puf_challenge_sequencer;

  localparam int RUN_CYCLES = 657;

  typedef struct {
    logic [15:0] key;
    logic [4:0]  unst;
    int          cycle;
  } done_exp_t;

  logic clk;
  logic rst;
  int   cycleCnt;
  int   checks;
  int   errors;
  int   respMode;
  int   voteIdx;
  logic prevPulse;
  logic postDone;
  done_exp_t lastDone;

  logic [7:0] expChal[$];
  done_exp_t  expDone[$];

  puf_challenge_sequencer_if #(.C_LENGTH(8), .N_RESP(16)) bus ();

  puf_challenge_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  function automatic logic [7:0] lfsrNext(input logic [7:0] c);
    return {c[6:0], ^(c & 8'hB8)};
  endfunction

  // Expected challenge per pulse plus the run result. Mode 0: response
  // tied 1. Mode 1: response = challenge[0]. Mode 2: 1,0,1,0,1 on the votes
  // of challenge 0, otherwise 0.
  task automatic pushRun(input logic [7:0] seed, input int mode, input int c0);
    logic [7:0] table6 [6];
    logic [7:0] chal;
    done_exp_t  d;
    table6[0] = 8'h01; table6[1] = 8'h02; table6[2] = 8'h04;
    table6[3] = 8'h08; table6[4] = 8'h11; table6[5] = 8'h23;
    chal   = (seed == 8'h00) ? 8'h01 : seed;
    d.key  = '0;
    d.unst = (mode == 2) ? 5'd1 : 5'd0;
    d.cycle = c0 + RUN_CYCLES;
    for (int i = 0; i < 16; i++) begin
      if (seed == 8'h01 && i < 6) chal = table6[i];
      for (int v = 0; v < 5; v++) expChal.push_back(chal);
      case (mode)
        0:       d.key[i] = 1'b1;
        1:       d.key[i] = chal[0];
        default: d.key[i] = (i == 0);
      endcase
      chal = lfsrNext(chal);
    end
    expDone.push_back(d);
  endtask

  task automatic applyStimulus(input logic [7:0] seed, input int mode, output int c0);
    @(negedge clk);
    respMode  = mode;
    bus.seed  = seed;
    bus.start = 1'b1;
    c0 = cycleCnt;
    pushRun(seed, mode, c0);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && expDone.size() != 0; i++) @(negedge clk);
    if (expDone.size() != 0) begin
      failNow("done_timeout");
      expDone.delete();
      expChal.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_challenge"}, 32'(bus.challenge), 0);
    checkOutput({tag, "_puf_pulse"}, 32'(bus.puf_pulse), 0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
    checkOutput({tag, "_done"}, 32'(bus.done), 0);
    checkOutput({tag, "_key"}, 32'(bus.key), 0);
    checkOutput({tag, "_key_valid"}, 32'(bus.key_valid), 0);
    checkOutput({tag, "_unstable_cnt"}, 32'(bus.unstable_cnt), 0);
  endtask

  // Monitor and PUF model, sampling 2 time units after each rising edge.
  always begin
    logic [7:0] ec;
    done_exp_t  ed;
    @(posedge clk);
    #2;
    if (!bus.busy) voteIdx = 0;
    if (bus.puf_pulse && !prevPulse) begin
      if (expChal.size() != 0) begin
        ec = expChal.pop_front();
        checkOutput("challenge", 32'(bus.challenge), 32'(ec));
      end else begin
        failNow("unexpected_pulse");
      end
      if (respMode == 2) bus.puf_response = (voteIdx < 5) ? ~voteIdx[0] : 1'b0;
      voteIdx++;
    end
    prevPulse = bus.puf_pulse;
    if (respMode == 0) bus.puf_response = 1'b1;
    else if (respMode == 1) bus.puf_response = bus.challenge[0];
    if (bus.done) begin
      if (expDone.size() != 0) begin
        ed = expDone.pop_front();
        checkOutput("done_cycle", 32'(cycleCnt), 32'(ed.cycle));
        checkOutput("done_key", 32'(bus.key), 32'(ed.key));
        checkOutput("done_unstable", 32'(bus.unstable_cnt), 32'(ed.unst));
        checkOutput("done_key_valid", 32'(bus.key_valid), 1);
        checkOutput("done_busy", 32'(bus.busy), 1);
        lastDone = ed;
        postDone = 1'b1;
      end else begin
        failNow("unexpected_done");
      end
    end else if (postDone) begin
      postDone = 1'b0;
      checkOutput("post_busy", 32'(bus.busy), 0);
      checkOutput("post_key_valid", 32'(bus.key_valid), 1);
      checkOutput("post_key", 32'(bus.key), 32'(lastDone.key));
    end
  end

  initial begin
    int c0;
    checks = 0; errors = 0; cycleCnt = 0; respMode = 0; voteIdx = 0;
    prevPulse = 1'b0; postDone = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.seed = 8'h00; bus.puf_response = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkAllZero("reset");

    $display("[TB] run: response tied 1, seed 01, extra start at +100");
    applyStimulus(8'h01, 0, c0);
    while (cycleCnt < c0 + 100) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(800);

    $display("[TB] run: response = challenge[0], seed 00");
    applyStimulus(8'h00, 1, c0);
    waitDone(800);

    $display("[TB] run: toggling votes on challenge 0");
    applyStimulus(8'h5A, 2, c0);
    waitDone(800);

    $display("[TB] run: abort at +200");
    applyStimulus(8'h01, 0, c0);
    while (cycleCnt < c0 + 200) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 0);
    checkOutput("abort_puf_pulse", 32'(bus.puf_pulse), 0);
    checkOutput("abort_key_valid", 32'(bus.key_valid), 0);
    checkOutput("abort_done", 32'(bus.done), 0);
    expChal.delete();
    expDone.delete();
    repeat (5) @(negedge clk);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("abort_start_busy", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);

    $display("[TB] run: restart after abort");
    applyStimulus(8'h01, 0, c0);
    waitDone(800);

    $display("[TB] run: reset mid-run");
    applyStimulus(8'h33, 0, c0);
    repeat (60) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkAllZero("midrun_reset");
    expChal.delete();
    expDone.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Challenge-side driver for the 8-stage arbiter PUF. It generates a sequence of challenges from an LFSR and launches a race edge into the PUF delay line for each one. It samples the arbiter response through a synchronizer, majority-votes repeated trials per challenge, and assembles an N_RESP-bit response word (key). It sits between the tile's control inputs and the PUF, driving the PUF's pulse and challenge inputs and consuming its response.

## Interface
- C_LENGTH, 8: challenge width; equals PUF mux-chain length.
- N_RESP, 16: challenges per run, which is also the key width.
- VOTES, 5: trials per challenge; odd, ≥1.
- SETTLE, 4: cycles per pulse phase (low and high); ≥3.
- LFSR_TAPS, 8'hB8: feedback mask, width C_LENGTH (x^8+x^6+x^5+x^4+1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel a run in progress.
- seed  in  C_LENGTH  initial challenge.
- challenge  out  C_LENGTH  challenge to PUF; registered.
- puf_pulse  out  1  race launch edge to PUF; registered.
- puf_response  in  1  arbiter output; asynchronous to clk.
- busy  out  1  high from start acceptance through the DONE cycle.
- done  out  1  one-cycle pulse at run completion.
- key  out  N_RESP  voted responses; key[i] is the result for challenge i.
- key_valid  out  1  key complete; held until next accepted start.
- unstable_cnt  out  clog2(N_RESP+1)  number of challenges with non-unanimous votes.

## Operation
- Reset: challenge=0, puf_pulse=0, busy=0, done=0, key=0, key_valid=0, unstable_cnt=0, state=IDLE.
- puf_response passes through a 2-flop synchronizer. Only the synchronized value is used.
- States: IDLE, ARM, FIRE, COMMIT, DONE.
- IDLE, start=1 (cycle t): the following are loaded at t+1:
  - challenge = seed, or C_LENGTH'h1 if seed==0.
  - key=0, unstable_cnt=0, key_valid=0.
  - Vote, ones and index counters cleared.
  - busy=1.
  - State becomes ARM.
- ARM: puf_pulse=0 for SETTLE cycles, then FIRE.
- FIRE: puf_pulse=1 for SETTLE cycles.
  - On the last FIRE cycle, the synchronized response is sampled and added to the ones counter; the vote counter increments.
  - If votes < VOTES, go to ARM. Otherwise go to COMMIT.
- COMMIT (1 cycle, puf_pulse=0):
  - key[index] = (ones > VOTES/2).
  - unstable_cnt increments if ones∉{0,VOTES}.
  - challenge advances as {challenge[C_LENGTH-2:0], ^(challenge & LFSR_TAPS)}.
  - ones and votes are cleared.
  - If index==N_RESP-1, go to DONE. Otherwise index increments and state goes to ARM.
- DONE (1 cycle): done=1, key_valid=1, busy=1. Then IDLE with busy=0.
- challenge holds its last value in IDLE.
- start while busy: ignored.
- abort=1 in any non-IDLE state: next cycle is IDLE with:
  - puf_pulse=0, busy=0, key_valid=0.
  - No done pulse.
  - key and unstable_cnt hold partial values (don't-care).
- abort and start in the same IDLE cycle: abort wins, and the start is not accepted.
- abort during DONE: the DONE outputs still complete.
- Reset mid-run: immediate return to reset values, with no glitch on puf_pulse beyond the async clear.
- LFSR never reaches all-zero, because the zero seed is remapped.

## Timing
- Per vote: 2·SETTLE cycles. Per challenge: 2·SETTLE·VOTES + 1 cycles.
- start accepted at t: first ARM cycle is t+1; done=1 at t+1+N_RESP·(2·SETTLE·VOTES+1). With defaults this is t+657.
- puf_pulse rising edges occur at t+1+SETTLE+k·2·SETTLE within each challenge.
- Response sample point is 2 cycles of synchronizer latency after the PUF input, within the same FIRE phase. This requires SETTLE≥3.
- challenge changes only in the cycle after COMMIT, while puf_pulse=0. It is stable across every ARM/FIRE window.

## Test plan
- Reset, then idle 10 cycles: all outputs 0; rst asserted mid-run returns every output to 0 in the same cycle.
- puf_response tied 1, seed=8'h01, start at t:
  - challenge sequence is 01,02,04,08,11,23.
  - done only at t+657; key=16'hFFFF, key_valid=1, unstable_cnt=0, busy=0 at t+658.
- seed=8'h00: first challenge is 8'h01. Response model = challenge[0]: key[4:0]=5'b10001.
- Response toggles 1,0,1,0,1 across the votes of challenge 0 only, otherwise 0: key=16'h0001, unstable_cnt=1.
- start pulsed again at t+100 is ignored; done still at t+657.
- abort at t+200: busy=0 at t+201, puf_pulse=0, no done pulse, key_valid=0.
- A new start after abort behaves as the second scenario.
